// File: rtl/grant_decoder_arb8.sv
// grant_decoder_arb8: eight-way round-robin arbiter with one-hot grant, hold limit and zero-bubble handover
module grant_decoder_arb8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt, r_idx, w_idx_nxt, w_win;
  logic [7:0] r_gnt, w_gnt_nxt, r_hold, w_hold_nxt;
  logic       r_vld, w_vld_nxt, w_rel, w_others, w_load;
  // rotating priority search: ptr+1 first, ptr itself last
  always_comb begin
    w_win = r_ptr;
    for (int k = 8; k >= 1; k--)
      if (req[r_ptr + 3'(k)]) w_win = r_ptr + 3'(k);
  end
  // release conditions of the current owner and whether anyone else is waiting
  always_comb begin
    w_rel    = !req[r_idx] || (MAX_HOLD != 0 && r_hold == HOLD_LAST);
    w_others = |(req & ~(8'd1 << r_idx));
    w_load   = (r_state == IDLE) ? |req : (w_rel && w_others);
  end
  // next state and registered-output values
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_gnt_nxt   = r_gnt;
    w_vld_nxt   = r_vld;
    w_hold_nxt  = r_hold;
    if (w_load) begin
      w_state_nxt = GRANT;
      w_ptr_nxt   = w_win;
      w_idx_nxt   = w_win;
      w_gnt_nxt   = 8'd1 << w_win;
      w_vld_nxt   = 1'b1;
      w_hold_nxt  = 8'd0;
    end else if (r_state == GRANT) begin
      if (!w_rel) begin
        w_hold_nxt = (r_hold == 8'hFF) ? 8'hFF : r_hold + 8'd1;
      end else if (req[r_idx]) begin
        w_hold_nxt = 8'd0;
      end else begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 8'd0;
        w_vld_nxt   = 1'b0;
        w_hold_nxt  = 8'd0;
      end
    end
  end
  // state and output registers; ptr starts at 7 so the first search begins at client 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd7;
      r_idx   <= 3'd0;
      r_gnt   <= 8'd0;
      r_vld   <= 1'b0;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_gnt   <= w_gnt_nxt;
      r_vld   <= w_vld_nxt;
      r_hold  <= w_hold_nxt;
    end
  end
  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
endmodule

// File: tb/tb_grant_decoder_arb8.sv
// tb_grant_decoder_arb8: random and directed checks of two arbiter instances against a grant-length model
module tb_grant_decoder_arb8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  int total = 0;
  int bad = 0;
  int m_busy[2], m_own[2], m_ptr[2], m_cnt[2], m_idx[2];
  int maxh[2] = '{16, 4};

  always #5 clk = ~clk;

  grant_decoder_arb8 u_a (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a));
  grant_decoder_arb8 #(.MAX_HOLD(4)) u_b (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(int p, logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return p;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_busy[n] = 0;
      m_own[n]  = 0;
      m_ptr[n]  = 7;
      m_idx[n]  = 0;
      m_cnt[n]  = 0;
    end
  endtask

  task automatic take(int n, int w);
    m_busy[n] = 1;
    m_own[n]  = w;
    m_ptr[n]  = w;
    m_idx[n]  = w;
    m_cnt[n]  = 1;
  endtask

  task automatic model_step(logic [7:0] r);
    for (int n = 0; n < 2; n++) begin
      if (!m_busy[n]) begin
        if (r != 0) take(n, search(m_ptr[n], r));
      end else if (r[m_own[n]] && !(maxh[n] != 0 && m_cnt[n] == maxh[n])) begin
        m_cnt[n]++;
      end else if ((r & ~(8'd1 << m_own[n])) != 0) begin
        take(n, search(m_own[n], r));
      end else if (r[m_own[n]]) begin
        m_cnt[n] = 1;
      end else begin
        m_busy[n] = 0;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_gnt_a"}, 32'(gnt_a), m_busy[0] ? 32'd1 << m_own[0] : 32'd0);
    chk({tag, "_idx_a"}, 32'(idx_a), 32'(m_idx[0]));
    chk({tag, "_vld_a"}, 32'(vld_a), 32'(m_busy[0]));
    chk({tag, "_gnt_b"}, 32'(gnt_b), m_busy[1] ? 32'd1 << m_own[1] : 32'd0);
    chk({tag, "_idx_b"}, 32'(idx_b), 32'(m_idx[1]));
    chk({tag, "_vld_b"}, 32'(vld_b), 32'(m_busy[1]));
  endtask

  task automatic cyc(string tag, logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1 check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1 model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    model_reset();
    do_reset();
    cyc("first", 8'hFF);
    chk("first_gnt", 32'(gnt_a), 32'h01);
    cyc("drop", 8'h00);
    repeat (5) cyc("single", 8'h08);
    repeat (2) cyc("single_off", 8'h00);
    chk("single_idx_hold", 32'(idx_a), 32'd3);
    for (int i = 0; i < 12; i++) begin
      r = (m_busy[0] && m_cnt[0] == 2) ? 8'h28 & ~(8'd1 << m_own[0]) : 8'h28;
      cyc("rotate", r);
      if (i > 0) chk("rotate_vld", 32'(vld_a), 32'd1);
    end
    repeat (2) cyc("idle", 8'h00);
    do_reset();
    repeat (12) cyc("fair", 8'h81);
    do_reset();
    repeat (2) cyc("pre6", 8'h40);
    cyc("gap", 8'h00);
    repeat (12) cyc("wrap", 8'h83);
    repeat (10) begin
      cyc("sole", 8'h04);
      chk("sole_gnt_b", 32'(gnt_b), 32'h04);
    end
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(i < 400 ? 3 : 24) == 0) r = 8'($urandom_range(255) & $urandom_range(255));
      cyc("rand", r);
    end
    do_reset();
    cyc("pre5", 8'h20);
    cyc("pre5", 8'h20);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("async_gnt", 32'(gnt_a), 32'd0);
    check_all("async");
    @(posedge clk);
    #1 check_all("async_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("after_rst", 8'h21);
    chk("after_rst_idx", 32'(idx_a), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grant_decoder_arb8.md
# grant_decoder_arb8

Eight-requester round-robin arbiter that shares one resource among up to eight clients and drives a one-hot grant vector, equivalent to a 3:8 decode of the winning index. It sits in front of any shared datapath port whose select is a 3-bit index. It adds grant hold, a fairness timeout and wrap-around rotation.

## Interface

- MAX_HOLD, 16: maximum consecutive cycles one grant may be held. Legal range is 1..255. 0 means unlimited.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector. Bit i is client i. A client holds its bit high for as long as it wants the resource.
- gnt  output  8  one-hot grant. All zeros when idle.
- gnt_idx  output  3  binary index of the granted client. Holds the last value when idle.
- gnt_vld  output  1  high whenever gnt is non-zero.

## Operation

- Internal state:
  - FSM: IDLE, GRANT.
  - ptr[2:0]: index of the last granted client.
  - hold_cnt[7:0]: cycles spent in the current grant.
- Search rule: scan req starting at ptr+1 mod 8 and ascending with wrap (7 → 0). The first set bit wins. The current owner is scanned last, so it wins only if no other client requests.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise: apply the search rule. Load gnt = 1<<win, gnt_idx = win, ptr = win, hold_cnt = 0. Go to GRANT.
- GRANT: a release condition exists when req[gnt_idx] == 0, or when MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
  - No release: stay in GRANT; hold_cnt increments.
  - Release with req == 0, or with only the releasing owner's bit set after a drop: clear gnt and gnt_vld. Go to IDLE.
  - Release, other requests pending: hand over in the same edge to the search winner. hold_cnt = 0, no idle bubble.
  - Timeout, owner still requesting, no one else requesting: regrant the same client. gnt stays high continuously; hold_cnt reloads to 0.
- Outputs are registered. gnt is always one-hot or zero, never multi-hot. gnt_idx always matches gnt when gnt_vld == 1.
- A requester that drops req without ever being granted is simply skipped. There is no request latching.
- Reset values: gnt = 0, gnt_idx = 0, gnt_vld = 0, ptr = 7 (so the first search starts at client 0), hold_cnt = 0, state = IDLE.
- An asserted rst_n clears all state immediately, mid-grant included. After release, operation resumes from the reset values.

## Timing

- Request-to-grant latency: 1 cycle. A req sampled high at edge N in IDLE gives gnt high after edge N.
- Release-to-handover: 0 bubble cycles. The owner's req low at edge N means the next owner's gnt is visible after edge N.
- Grant length with MAX_HOLD = M and the owner holding req high: exactly M cycles of gnt, then handover at the next edge.
- Grant length with MAX_HOLD = 0: unbounded. hold_cnt saturates at 255 and does not wrap.
- Simultaneous new requests at one edge: resolved purely by the rotation order from ptr+1.
- req changes between edges have no effect. Only values at the rising edge matter.
- No combinational path from req to any output.

## Test plan

- Reset behaviour:
  - Stimulus: hold rst_n = 0 with req = 8'hFF.
  - Response: gnt = 0, gnt_vld = 0, gnt_idx = 0. After release, first gnt = 8'b0000_0001 one cycle later.
- Single requester:
  - Stimulus: req = 8'b0000_1000 for 5 cycles, then 0.
  - Response: gnt = 8'b0000_1000 and gnt_idx = 3 for 5 cycles. Then gnt = 0 and gnt_vld = 0. gnt_idx stays 3.
- Rotation and zero-bubble handover:
  - Stimulus: req = 8'b0010_1000. Each owner drops its bit for 1 cycle after 2 cycles of grant, then re-raises it.
  - Response: grants alternate idx 3, 5, 3, 5 with gnt_vld continuously high.
- Fairness timeout (MAX_HOLD = 4):
  - Stimulus: req = 8'b1000_0001 held constant, after reset.
  - Response: idx 0 for 4 cycles, idx 7 for 4 cycles, idx 0 for 4 cycles.
- Wrap-around and sole-owner regrant (MAX_HOLD = 4):
  - Stimulus: ptr = 6 via a prior grant to 6, then req = 8'b1000_0011 held.
  - Response: order is 7 → 0 → 1 → 7.
  - Follow-up: with only req[2] held, gnt = 8'b0000_0100 stays high with no gap across timeouts.
- Reset mid-grant:
  - Stimulus: assert rst_n low asynchronously while idx 5 is granted.
  - Response: gnt drops to 0 immediately, before the next edge. After release with req = 8'b0010_0001, the first winner is idx 0.
